// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone arbiter family.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module wb_rr_pick #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_oh = '0;
        idx      = '0;
        valid    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        if (valid) grant_oh[idx] = 1'b1;
    end

endmodule

// File: rtl/wb_rr_arbiter_wdt.sv
// Round-robin Wishbone arbiter sharing one slave among NUM_MASTERS masters,
// with a per-access watchdog that aborts unanswered cycles with an error.
module wb_rr_arbiter_wdt
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic [TMO_CNT_W-1:0]        tmo_cnt_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_e           state;
    logic [IW-1:0]        gidx;
    logic [IW-1:0]        last_grant;
    logic                 abort_first;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_valid;
    logic                 slave_resp;
    logic                 wdt_fire;

    logic [AW-1:0]   m_adr [NUM_MASTERS];
    logic [DW-1:0]   m_dat [NUM_MASTERS];
    logic [DW/8-1:0] m_sel [NUM_MASTERS];
    logic [2:0]      m_cti [NUM_MASTERS];
    logic [1:0]      m_bte [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign m_adr[i] = wbm_adr_i[i*AW +: AW];
        assign m_dat[i] = wbm_dat_i[i*DW +: DW];
        assign m_sel[i] = wbm_sel_i[i*(DW/8) +: DW/8];
        assign m_cti[i] = wbm_cti_i[i*3 +: 3];
        assign m_bte[i] = wbm_bte_i[i*2 +: 2];
    end

    wb_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req      (wbm_cyc_i),
        .last     (last_grant),
        .grant_oh (pick_oh),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign wbm_dat_o  = {NUM_MASTERS{wbs_dat_i}};

    // Slave side and responses are gated by state so reset clears them at once.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        if (state == GRANT) begin
            wbs_adr_o       = m_adr[gidx];
            wbs_dat_o       = m_dat[gidx];
            wbs_sel_o       = m_sel[gidx];
            wbs_we_o        = wbm_we_i[gidx];
            wbs_cyc_o       = wbm_cyc_i[gidx];
            wbs_stb_o       = wbm_stb_i[gidx];
            wbs_cti_o       = m_cti[gidx];
            wbs_bte_o       = m_bte[gidx];
            wbm_ack_o[gidx] = wbs_ack_i;
            wbm_err_o[gidx] = wbs_err_i;
            wbm_rty_o[gidx] = wbs_rty_i;
        end else if (state == ABORT && abort_first) begin
            wbm_err_o[gidx] = 1'b1;
        end
    end

    if (TIMEOUT > 0) begin : g_wdt
        localparam int CW = $clog2(TIMEOUT + 1);
        localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
        logic [CW-1:0] cnt;

        // A response in the threshold cycle suppresses the abort.
        assign wdt_fire = (state == GRANT) && wbs_stb_o && !slave_resp && (cnt == LAST);

        always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni)
                cnt <= '0;
            else if (state != GRANT || !wbs_stb_o || slave_resp || wdt_fire)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end else begin : g_no_wdt
        assign wdt_fire = 1'b0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            gidx        <= '0;
            last_grant  <= IW'(NUM_MASTERS - 1);
            grant_o     <= '0;
            tmo_cnt_o   <= '0;
            abort_first <= 1'b0;
        end else begin
            abort_first <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= GRANT;
                        gidx    <= pick_idx;
                        grant_o <= pick_oh;
                    end
                end
                GRANT: begin
                    // Master release takes priority over a coincident timeout.
                    if (!wbm_cyc_i[gidx]) begin
                        state      <= IDLE;
                        last_grant <= gidx;
                        grant_o    <= '0;
                    end else if (wdt_fire) begin
                        state       <= ABORT;
                        abort_first <= 1'b1;
                        if (tmo_cnt_o != '1) tmo_cnt_o <= tmo_cnt_o + 1'b1;
                    end
                end
                ABORT: begin
                    if (!wbm_cyc_i[gidx]) begin
                        state      <= IDLE;
                        last_grant <= gidx;
                        grant_o    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter_wdt.sv
// Directed bench for wb_rr_arbiter_wdt: 2 masters, TIMEOUT=8.
module tb_wb_rr_arbiter_wdt;
    import wb_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [63:0] m_adr;
    logic [63:0] m_dat;
    logic [7:0]  m_sel;
    logic [1:0]  m_we, m_cyc, m_stb;
    logic [5:0]  m_cti;
    logic [3:0]  m_bte;
    logic [63:0] wbm_dat_o;
    logic [1:0]  wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [31:0] wbs_adr_o, wbs_dat_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]  wbs_cti_o;
    logic [1:0]  wbs_bte_o;
    logic [31:0] s_dat;
    logic        s_ack, s_err, s_rty;
    logic [1:0]  grant_o;
    logic [7:0]  tmo_cnt_o;

    int checks = 0;
    int errors = 0;

    wb_rr_arbiter_wdt #(.NUM_MASTERS(2), .AW(32), .DW(32), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(grant_o), .tmo_cnt_o(tmo_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        m_cti = '0; m_bte = '0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        repeat (3) tick();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant_o); end
        checks++; if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0) begin errors++; $display("FAIL reset_wbs cyc=%b stb=%b exp 0 0", wbs_cyc_o, wbs_stb_o); end
        checks++; if (tmo_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_tmo got %0d exp 0", tmo_cnt_o); end
        checks++; if (wbm_ack_o !== 2'b00 || wbm_err_o !== 2'b00) begin errors++; $display("FAIL reset_resp ack=%b err=%b exp 00 00", wbm_ack_o, wbm_err_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rr_basic();
        m_adr = {32'h0000_0200, 32'h0000_0100};
        m_cyc = 2'b11; m_stb = 2'b11; m_sel = 8'hFF;
        tick();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rr_first_grant got %b exp 01", grant_o); end
        checks++; if (wbs_adr_o !== 32'h100 || wbs_cyc_o !== 1'b1) begin errors++; $display("FAIL rr_m0_route adr=%h cyc=%b exp 100 1", wbs_adr_o, wbs_cyc_o); end
        checks++; if (wbm_ack_o !== 2'b00) begin errors++; $display("FAIL rr_no_early_ack got %b exp 00", wbm_ack_o); end
        s_ack = 1'b1; s_dat = 32'hCAFE_F00D;
        #1;
        checks++; if (wbm_ack_o !== 2'b01) begin errors++; $display("FAIL rr_m0_ack got %b exp 01", wbm_ack_o); end
        checks++; if (wbm_dat_o !== {2{32'hCAFE_F00D}}) begin errors++; $display("FAIL rr_dat_bcast got %h exp cafef00dcafef00d", wbm_dat_o); end
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0;
        #1;
        checks++; if (grant_o !== 2'b01 || wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL rr_m0_release grant=%b cyc=%b exp 01 0", grant_o, wbs_cyc_o); end
        tick();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rr_idle_gap got %b exp 00", grant_o); end
        tick();
        checks++; if (grant_o !== 2'b10 || wbs_adr_o !== 32'h200) begin errors++; $display("FAIL rr_second_grant grant=%b adr=%h exp 10 200", grant_o, wbs_adr_o); end
        s_ack = 1'b1;
        tick();
        m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_burst();
        m_cyc = 2'b10; m_stb = 2'b10; m_cti = {CTI_INCR, CTI_CLASSIC};
        tick();
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL burst_grant got %b exp 10", grant_o); end
        m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m_cti[5:3] = (b == 3) ? CTI_EOB : CTI_INCR;
            #1;
            checks++; if (grant_o !== 2'b10 || wbm_ack_o !== 2'b10) begin errors++; $display("FAIL burst_beat%0d grant=%b ack=%b exp 10 10", b, grant_o, wbm_ack_o); end
            checks++; if (wbs_cti_o !== m_cti[5:3]) begin errors++; $display("FAIL burst_cti%0d got %b exp %b", b, wbs_cti_o, m_cti[5:3]); end
            tick();
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0;
        #1;
        checks++; if (wbm_ack_o !== 2'b00) begin errors++; $display("FAIL burst_no_m0_ack got %b exp 00", wbm_ack_o); end
        tick();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL burst_idle got %b exp 00", grant_o); end
        tick();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL burst_m0_after got %b exp 01", grant_o); end
        m_cyc = 2'b00; m_stb = 2'b00; m_cti = '0;
        repeat (2) tick();
    endtask

    task automatic test_timeout();
        int stb_cycles = 0;
        int err_cycles = 0;
        checks++; if (tmo_cnt_o !== 8'd0) begin errors++; $display("FAIL tmo_before got %0d exp 0", tmo_cnt_o); end
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        for (int c = 0; c < 12; c++) begin
            if (wbs_stb_o) stb_cycles++;
            if (wbm_err_o[0]) err_cycles++;
            tick();
        end
        checks++; if (stb_cycles != 8) begin errors++; $display("FAIL tmo_stb_cycles got %0d exp 8", stb_cycles); end
        checks++; if (err_cycles != 1) begin errors++; $display("FAIL tmo_err_pulse got %0d exp 1", err_cycles); end
        checks++; if (tmo_cnt_o !== 8'd1) begin errors++; $display("FAIL tmo_count got %0d exp 1", tmo_cnt_o); end
        checks++; if (grant_o !== 2'b01 || wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL tmo_hold grant=%b cyc=%b exp 01 0", grant_o, wbs_cyc_o); end
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL tmo_release got %b exp 00", grant_o); end
        tick();
    endtask

    task automatic test_ack_at_threshold();
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        repeat (7) tick();
        s_ack = 1'b1;
        #1;
        checks++; if (wbm_ack_o !== 2'b01 || wbm_err_o !== 2'b00) begin errors++; $display("FAIL thr_ack ack=%b err=%b exp 01 00", wbm_ack_o, wbm_err_o); end
        tick();
        s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
        #1;
        checks++; if (grant_o !== 2'b01 || wbm_err_o !== 2'b00) begin errors++; $display("FAIL thr_no_abort grant=%b err=%b exp 01 00", grant_o, wbm_err_o); end
        checks++; if (tmo_cnt_o !== 8'd1) begin errors++; $display("FAIL thr_tmo got %0d exp 1", tmo_cnt_o); end
        repeat (2) tick();
    endtask

    task automatic one_timeout();
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        repeat (8) tick();
        m_cyc = 2'b00; m_stb = 2'b00;
        repeat (2) tick();
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 253; n++) one_timeout();
        checks++; if (tmo_cnt_o !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", tmo_cnt_o); end
        for (int n = 0; n < 47; n++) one_timeout();
        checks++; if (tmo_cnt_o !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", tmo_cnt_o); end
    endtask

    task automatic test_reset_mid_burst();
        m_cyc = 2'b11; m_stb = 2'b11; m_cti = {CTI_INCR, CTI_INCR};
        tick();
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL mid_grant got %b exp 10", grant_o); end
        s_ack = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (wbs_cyc_o !== 1'b0 || grant_o !== 2'b00) begin errors++; $display("FAIL mid_async cyc=%b grant=%b exp 0 00", wbs_cyc_o, grant_o); end
        checks++; if (wbm_ack_o !== 2'b00 || tmo_cnt_o !== 8'd0) begin errors++; $display("FAIL mid_async_resp ack=%b tmo=%0d exp 00 0", wbm_ack_o, tmo_cnt_o); end
        s_ack = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL mid_m0_priority got %b exp 01", grant_o); end
        m_cyc = 2'b00; m_stb = 2'b00;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_rr_basic();
        test_burst();
        test_timeout();
        test_ack_at_threshold();
        test_saturation();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
